// File: rtl/ook_tone_transmitter.sv
// On-off-keyed tone framer: preamble, start, 8 data bits LSB first, stop, gap; one sample per tick, 1-cycle latency.
// Accepts a byte only in IDLE (axiio high); offers while busy are not buffered.
module ook_tone_transmitter #(
    parameter int SAMPLE_DATA_WIDTH  = 8,
    parameter int SAMPLES_PER_SYMBOL = 64,
    parameter int HALF_PERIOD        = 4,
    parameter int AMPLITUDE          = 100,
    parameter int PREAMBLE_SYMBOLS   = 8,
    parameter int GAP_SYMBOLS        = 2
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                sample_tick,
    input  logic                                axiiv,
    input  logic [7:0]                          axiid,
    output logic                                axiio,
    output logic                                axiov,
    output logic signed [SAMPLE_DATA_WIDTH-1:0] axiod,
    output logic                                busy
);

    localparam int SYM_MAX = (PREAMBLE_SYMBOLS > GAP_SYMBOLS)
                           ? ((PREAMBLE_SYMBOLS > 8) ? PREAMBLE_SYMBOLS : 8)
                           : ((GAP_SYMBOLS > 8) ? GAP_SYMBOLS : 8);
    localparam int SYM_W  = $clog2(SYM_MAX);
    localparam int TICK_W = $clog2(SAMPLES_PER_SYMBOL);
    localparam int HALF_W = $clog2(HALF_PERIOD + 1);

    localparam logic [SAMPLE_DATA_WIDTH-1:0] AMP_POS = SAMPLE_DATA_WIDTH'(AMPLITUDE);
    localparam logic [SAMPLE_DATA_WIDTH-1:0] AMP_NEG = SAMPLE_DATA_WIDTH'(-AMPLITUDE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_START,
        S_DATA,
        S_STOP,
        S_GAP
    } state_t;

    state_t                         r_state, w_state_nxt;
    logic [7:0]                     r_byte, w_byte_nxt;
    logic [TICK_W-1:0]              r_tick_cnt, w_tick_nxt;
    logic [HALF_W-1:0]              r_half_cnt, w_half_nxt;
    logic                           r_phase, w_phase_nxt;
    logic [SYM_W-1:0]               r_sym_cnt, w_sym_nxt;
    logic                           r_axiov;
    logic [SAMPLE_DATA_WIDTH-1:0]   r_axiod;

    logic                           w_tone;
    logic                           w_last_sym;
    logic                           w_sym_end;
    logic [SAMPLE_DATA_WIDTH-1:0]   w_sample;

    assign axiio     = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign axiov     = r_axiov;
    assign axiod     = r_axiod;
    assign w_sym_end = (r_tick_cnt == TICK_W'(SAMPLES_PER_SYMBOL - 1));
    assign w_sample  = w_tone ? (r_phase ? AMP_NEG : AMP_POS) : '0;

    always_comb begin
        w_tone     = 1'b0;
        w_last_sym = 1'b1;
        case (r_state)
            S_PREAMBLE: begin
                w_tone     = 1'b1;
                w_last_sym = (r_sym_cnt == SYM_W'(PREAMBLE_SYMBOLS - 1));
            end
            S_DATA: begin
                w_tone     = r_byte[r_sym_cnt[2:0]];
                w_last_sym = (r_sym_cnt == SYM_W'(7));
            end
            S_STOP:  w_tone = 1'b1;
            S_GAP:   w_last_sym = (r_sym_cnt == SYM_W'(GAP_SYMBOLS - 1));
            default: w_last_sym = 1'b1;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_byte_nxt  = r_byte;
        w_tick_nxt  = r_tick_cnt;
        w_half_nxt  = r_half_cnt;
        w_phase_nxt = r_phase;
        w_sym_nxt   = r_sym_cnt;
        if (r_state == S_IDLE) begin
            if (axiiv) begin
                w_byte_nxt  = axiid;
                w_state_nxt = S_PREAMBLE;
                w_tick_nxt  = '0;
                w_half_nxt  = '0;
                w_phase_nxt = 1'b0;
                w_sym_nxt   = '0;
            end
        end else if (sample_tick) begin
            if (w_sym_end) begin
                // Every symbol boundary restarts the tone at the positive half-cycle.
                w_tick_nxt  = '0;
                w_half_nxt  = '0;
                w_phase_nxt = 1'b0;
                if (w_last_sym) begin
                    w_sym_nxt = '0;
                    case (r_state)
                        S_PREAMBLE: w_state_nxt = S_START;
                        S_START:    w_state_nxt = S_DATA;
                        S_DATA:     w_state_nxt = S_STOP;
                        S_STOP:     w_state_nxt = S_GAP;
                        default:    w_state_nxt = S_IDLE;
                    endcase
                end else begin
                    w_sym_nxt = r_sym_cnt + SYM_W'(1);
                end
            end else begin
                w_tick_nxt = r_tick_cnt + TICK_W'(1);
                if (r_half_cnt == HALF_W'(HALF_PERIOD - 1)) begin
                    w_half_nxt  = '0;
                    w_phase_nxt = ~r_phase;
                end else begin
                    w_half_nxt = r_half_cnt + HALF_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_byte     <= '0;
            r_tick_cnt <= '0;
            r_half_cnt <= '0;
            r_phase    <= 1'b0;
            r_sym_cnt  <= '0;
            r_axiov    <= 1'b0;
            r_axiod    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_byte     <= w_byte_nxt;
            r_tick_cnt <= w_tick_nxt;
            r_half_cnt <= w_half_nxt;
            r_phase    <= w_phase_nxt;
            r_sym_cnt  <= w_sym_nxt;
            r_axiov    <= sample_tick;
            if (sample_tick) begin
                r_axiod <= w_sample;
            end
        end
    end

endmodule

// File: tb/tb_ook_tone_transmitter.sv
// Bench for ook_tone_transmitter: per-frame sample-list model, per-cycle compare, directed and random stimulus.
module tb_ook_tone_transmitter;

    localparam int SPS  = 4;
    localparam int HP   = 2;
    localparam int PRE  = 2;
    localparam int GAPS = 1;
    localparam int AMP  = 100;
    localparam int AMP2 = 127;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              sample_tick = 1'b0;
    logic              axiiv = 1'b0;
    logic [7:0]        axiid = 8'h00;
    logic              axiio, axiov, busy;
    logic signed [7:0] axiod;
    logic              axiio2, axiov2, busy2;
    logic signed [7:0] axiod2;

    int   tests = 0;
    int   fails = 0;
    int   q[$];
    int   q2[$];
    int   exp_dat = 0;
    int   exp_dat2 = 0;
    logic exp_vld = 1'b0;
    bit   m_idle;
    bit   started = 1'b0;
    int   cap[$];
    int   cap2[$];
    logic cap_arm = 1'b0;

    ook_tone_transmitter #(
        .SAMPLE_DATA_WIDTH(8), .SAMPLES_PER_SYMBOL(SPS), .HALF_PERIOD(HP),
        .AMPLITUDE(AMP), .PREAMBLE_SYMBOLS(PRE), .GAP_SYMBOLS(GAPS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .axiiv(axiiv), .axiid(axiid),
        .axiio(axiio), .axiov(axiov), .axiod(axiod), .busy(busy)
    );

    ook_tone_transmitter #(
        .SAMPLE_DATA_WIDTH(8), .SAMPLES_PER_SYMBOL(SPS), .HALF_PERIOD(HP),
        .AMPLITUDE(AMP2), .PREAMBLE_SYMBOLS(PRE), .GAP_SYMBOLS(GAPS)
    ) dut127 (
        .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .axiiv(axiiv), .axiid(axiid),
        .axiio(axiio2), .axiov(axiov2), .axiod(axiod2), .busy(busy2)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Whole frame as a flat list of samples: one tone flag per symbol, SPS samples each.
    function automatic void push_frame(logic [7:0] b);
        int flags[$];
        int sgn;
        for (int i = 0; i < PRE; i++) flags.push_back(1);
        flags.push_back(0);
        for (int i = 0; i < 8; i++) flags.push_back(int'(b[i]));
        flags.push_back(1);
        for (int i = 0; i < GAPS; i++) flags.push_back(0);
        foreach (flags[s]) begin
            for (int k = 0; k < SPS; k++) begin
                sgn = (((k / HP) % 2) == 0) ? 1 : -1;
                q.push_back(flags[s] * sgn * AMP);
                q2.push_back(flags[s] * sgn * AMP2);
            end
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            q2.delete();
            exp_vld  = 1'b0;
            exp_dat  = 0;
            exp_dat2 = 0;
        end else begin
            m_idle  = (q.size() == 0);
            exp_vld = sample_tick;
            if (sample_tick) begin
                if (m_idle) begin
                    exp_dat  = 0;
                    exp_dat2 = 0;
                end else begin
                    exp_dat  = q.pop_front();
                    exp_dat2 = q2.pop_front();
                end
            end
            if (m_idle && axiiv) push_frame(axiid);
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("axiov", int'(axiov), int'(exp_vld));
            check("axiod", int'(axiod), exp_dat);
            check("axiod_amp127", int'(axiod2), exp_dat2);
            check("axiio", int'(axiio), (q.size() == 0) ? 1 : 0);
            check("busy", int'(busy), (q.size() != 0) ? 1 : 0);
        end
    end

    always @(negedge clk) begin
        if (axiov && cap_arm) begin
            cap.push_back(int'(axiod));
            cap2.push_back(int'(axiod2));
        end
        cap_arm = sample_tick && busy;
    end

    initial begin
        int c = 0;
        forever begin
            @(posedge clk);
            #2;
            sample_tick = (c == 0);
            c = (c + 1) % 3;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [7:0] b);
        axiiv = 1'b1;
        axiid = b;
        step();
        axiiv = 1'b0;
    endtask

    task automatic wait_busy(input logic lvl, input int bound, input string name);
        int n = 0;
        while (busy !== lvl && n < bound) begin
            step();
            n++;
        end
        check(name, int'(busy), int'(lvl));
    endtask

    task automatic count_idle(input string name);
        int n = 0;
        while (busy == 1'b0 && n < 10) begin
            step();
            n++;
        end
        check(name, n, 1);
    endtask

    initial begin
        string pat;
        int    tv[4];
        int    bad;
        int    n;
        logic [7:0] b;

        #3;
        rst_n = 1'b0;
        started = 1'b1;
        repeat (3) step();
        check("rst_axiio", int'(axiio), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_axiov", int'(axiov), 0);
        check("rst_axiod", int'(axiod), 0);
        rst_n = 1'b1;

        n = 0;
        while (axiov !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        check("first_tick_vld", int'(axiov), 1);
        check("first_tick_zero", int'(axiod), 0);

        n = 0;
        repeat (60) begin
            step();
            if (axiov) n++;
        end
        check("idle_pulses", n, 20);

        // Single A5 frame against hand-written symbol pattern.
        wait_busy(1'b0, 300, "a5_idle");
        cap.delete();
        cap2.delete();
        send(8'hA5);
        wait_busy(1'b1, 5, "a5_start");
        wait_busy(1'b0, 300, "a5_done");
        repeat (3) step();
        check("a5_count", cap.size(), 52);
        pat = "TTSTSTSSTSTTS";
        tv = '{100, 100, -100, -100};
        bad = 0;
        for (int s = 0; s < 13; s++) begin
            for (int k = 0; k < 4; k++) begin
                if ((s * 4 + k) >= cap.size()) bad++;
                else if (cap[s * 4 + k] != ((pat[s] == "T") ? tv[k] : 0)) bad++;
            end
        end
        check("a5_pattern", bad, 0);
        check("amp127_pos", cap2[0] & 255, 'h7F);
        check("amp127_neg", cap2[2] & 255, 'h81);

        // Back-to-back FF then 00 with valid held high.
        wait_busy(1'b0, 300, "b2b_idle");
        cap.delete();
        axiiv = 1'b1;
        axiid = 8'hFF;
        step();
        axiid = 8'h00;
        wait_busy(1'b1, 5, "ff_start");
        wait_busy(1'b0, 300, "ff_done");
        count_idle("b2b_idle_cycles");
        axiiv = 1'b0;
        wait_busy(1'b0, 300, "00_done");
        repeat (3) step();
        check("b2b_count", cap.size(), 104);
        bad = 0;
        for (int i = 64; i < 96; i++) if (cap[i] != 0) bad++;
        check("b2b_second_data_zero", bad, 0);
        check("b2b_first_bit0", cap[12], 100);

        // 3C offered while busy is ignored, then taken at IDLE.
        cap.delete();
        b = 8'($urandom);
        send(b);
        wait_busy(1'b1, 5, "busy_offer_start");
        repeat (10) step();
        axiiv = 1'b1;
        axiid = 8'h3C;
        wait_busy(1'b0, 300, "busy_offer_done");
        count_idle("busy_offer_idle_cycles");
        axiiv = 1'b0;
        wait_busy(1'b0, 300, "3c_done");
        repeat (3) step();
        check("busy_offer_count", cap.size(), 104);
        check("3c_bit0", cap[64], 0);
        check("3c_bit2", cap[72], 100);

        // Reset in DATA bit 3 of A5.
        cap.delete();
        send(8'hA5);
        n = 0;
        while (cap.size() < 26 && n < 200) begin
            step();
            n++;
        end
        check("rst_reach_bit3", (cap.size() >= 26) ? 1 : 0, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_axiio", int'(axiio), 1);
        check("midrst_axiov", int'(axiov), 0);
        check("midrst_axiod", int'(axiod), 0);
        step();
        step();
        rst_n = 1'b1;
        n = 0;
        while (axiov !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        check("post_rst_first_vld", int'(axiov), 1);
        check("post_rst_first_zero", int'(axiod), 0);
        bad = 0;
        repeat (30) begin
            step();
            if (axiov && axiod != 0) bad++;
        end
        check("post_rst_silent", bad, 0);
        cap.delete();
        send(8'h01);
        wait_busy(1'b1, 5, "01_start");
        wait_busy(1'b0, 300, "01_done");
        repeat (3) step();
        check("01_count", cap.size(), 52);
        check("01_pre0", cap[0], 100);
        check("01_bit0", cap[12], 100);
        check("01_bit1", cap[16], 0);

        // Random offers against the model.
        repeat (3000) begin
            axiiv = ($urandom_range(0, 5) == 0);
            axiid = 8'($urandom);
            step();
        end
        axiiv = 1'b0;
        wait_busy(1'b0, 300, "rand_drain");
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
